// File: rtl/imem_loader.sv
// Boot-time program loader: assembles big-endian 16-bit words from a byte stream,
// writes them to instruction memory from address 0, and releases the core on a good checksum.
module imem_loader #(
  parameter int unsigned PC_WIDTH   = 16,
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned MEM_WORDS  = 32768
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  input  logic                  load_req,
  output logic                  imem_wr_en,
  output logic [PC_WIDTH-1:0]   imem_wr_addr,
  output logic [DATA_WIDTH-1:0] imem_wr_data,
  output logic                  core_hold,
  output logic                  load_done,
  output logic                  load_error,
  output logic [15:0]           words_loaded
);

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [2:0] {
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_CHK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t                state_q, state_nxt;
  logic [CNT_W-1:0]      len_q, len_nxt;
  logic [CNT_W-1:0]      idx_q, idx_nxt;
  logic [BYTE_W-1:0]     hi_q, hi_nxt;
  logic [BYTE_W-1:0]     chk_q, chk_nxt;
  logic                  wr_en_q, wr_en_nxt;
  logic [PC_WIDTH-1:0]   wr_addr_q, wr_addr_nxt;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_nxt;
  logic                  in_ready_q, in_ready_nxt;
  logic                  core_hold_q, core_hold_nxt;
  logic                  load_done_q, load_done_nxt;
  logic                  load_error_q, load_error_nxt;

  logic                  xfer;
  logic [CNT_W-1:0]      len_full;
  logic [CNT_W-1:0]      idx_inc;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_LEN_HI;
      len_q        <= '0;
      idx_q        <= '0;
      hi_q         <= '0;
      chk_q        <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      in_ready_q   <= 1'b1;
      core_hold_q  <= 1'b1;
      load_done_q  <= 1'b0;
      load_error_q <= 1'b0;
    end else begin
      state_q      <= state_nxt;
      len_q        <= len_nxt;
      idx_q        <= idx_nxt;
      hi_q         <= hi_nxt;
      chk_q        <= chk_nxt;
      wr_en_q      <= wr_en_nxt;
      wr_addr_q    <= wr_addr_nxt;
      wr_data_q    <= wr_data_nxt;
      in_ready_q   <= in_ready_nxt;
      core_hold_q  <= core_hold_nxt;
      load_done_q  <= load_done_nxt;
      load_error_q <= load_error_nxt;
    end
  end

  // in_ready_q always mirrors whether the current state accepts bytes
  assign xfer     = in_valid & in_ready_q;
  assign len_full = {len_q[15:8], in_data};
  assign idx_inc  = idx_q + CNT_W'(1);

  // Next-state and next-output logic
  always_comb begin
    state_nxt   = state_q;
    len_nxt     = len_q;
    idx_nxt     = idx_q;
    hi_nxt      = hi_q;
    chk_nxt     = chk_q;
    wr_en_nxt   = 1'b0;
    wr_addr_nxt = wr_addr_q;
    wr_data_nxt = wr_data_q;

    unique case (state_q)
      S_LEN_HI: begin
        if (xfer) begin
          len_nxt   = {in_data, len_q[7:0]};
          state_nxt = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_nxt = len_full;
          if ((len_full == '0) || (32'(len_full) > 32'(MEM_WORDS))) begin
            state_nxt = S_ERROR;
          end else begin
            idx_nxt   = '0;
            chk_nxt   = '0;
            state_nxt = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (xfer) begin
          hi_nxt    = in_data;
          chk_nxt   = chk_q ^ in_data;
          state_nxt = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (xfer) begin
          wr_en_nxt   = 1'b1;
          wr_addr_nxt = PC_WIDTH'({idx_q, 1'b0});
          wr_data_nxt = DATA_WIDTH'({hi_q, in_data});
          chk_nxt     = chk_q ^ in_data;
          idx_nxt     = idx_inc;
          state_nxt   = (idx_inc == len_q) ? S_CHK : S_DATA_HI;
        end
      end
      S_CHK: begin
        if (xfer) begin
          state_nxt = (in_data == chk_q) ? S_DONE : S_ERROR;
        end
      end
      S_DONE, S_ERROR: begin
        if (load_req) begin
          idx_nxt   = '0;
          state_nxt = S_LEN_HI;
        end
      end
      default: state_nxt = S_LEN_HI;
    endcase

    // Status outputs are registered copies of the decoded next state
    in_ready_nxt   = (state_nxt != S_DONE) && (state_nxt != S_ERROR);
    core_hold_nxt  = (state_nxt != S_DONE);
    load_done_nxt  = (state_nxt == S_DONE);
    load_error_nxt = (state_nxt == S_ERROR);
  end

  assign in_ready     = in_ready_q;
  assign imem_wr_en   = wr_en_q;
  assign imem_wr_addr = wr_addr_q;
  assign imem_wr_data = wr_data_q;
  assign core_hold    = core_hold_q;
  assign load_done    = load_done_q;
  assign load_error   = load_error_q;
  assign words_loaded = idx_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader: frames, bad lengths/checksums,
// stream gaps, mid-frame reset and load_req restarts.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        load_req = 1'b0;
  logic        imem_wr_en;
  logic [15:0] imem_wr_addr;
  logic [15:0] imem_wr_data;
  logic        core_hold;
  logic        load_done;
  logic        load_error;
  logic [15:0] words_loaded;

  int checks = 0;
  int failures = 0;
  int double_wr = 0;
  logic prev_wr = 1'b0;

  logic [15:0] log_addr[$];
  logic [15:0] log_data[$];
  logic [7:0]  frame[$];

  imem_loader #(.PC_WIDTH(16), .DATA_WIDTH(16), .MEM_WORDS(32768)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .load_req(load_req), .imem_wr_en(imem_wr_en), .imem_wr_addr(imem_wr_addr),
    .imem_wr_data(imem_wr_data), .core_hold(core_hold), .load_done(load_done),
    .load_error(load_error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  // Write logger, sampled mid-cycle
  always @(negedge clk) begin
    if (imem_wr_en) begin
      log_addr.push_back(imem_wr_addr);
      log_data.push_back(imem_wr_data);
      if (prev_wr) double_wr++;
    end
    prev_wr = imem_wr_en;
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    repeat (gap) begin
      in_valid = 1'b0; in_data = 8'hEE;
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_data = b;
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 8'h00;
  endtask

  // gap_mode 1: random idle cycles, and 5 idle cycles before byte index 3
  task automatic send_frame(input int gap_mode);
    for (int i = 0; i < frame.size(); i++) begin
      int g;
      g = 0;
      if (gap_mode == 1) g = (i == 3) ? 5 : int'($urandom_range(0, 3));
      send_byte(frame[i], g);
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_data.delete();
  endtask

  task automatic pulse_req();
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask

  task automatic check_writes(input string tag, input logic [15:0] ea[$], input logic [15:0] ed[$]);
    checks++;
    if (log_addr.size() !== ea.size()) begin
      failures++;
      $display("FAIL %s_count got=%0d exp=%0d", tag, log_addr.size(), ea.size());
    end else begin
      for (int i = 0; i < ea.size(); i++) begin
        checks++;
        if (log_addr[i] !== ea[i] || log_data[i] !== ed[i]) begin
          failures++;
          $display("FAIL %s_wr%0d got=%h:%h exp=%h:%h", tag, i, log_addr[i], log_data[i], ea[i], ed[i]);
        end
      end
    end
  endtask

  task automatic check_status(input string tag, input logic e_rdy, input logic e_hold,
                              input logic e_done, input logic e_err, input logic [15:0] e_words);
    checks++;
    if (in_ready !== e_rdy || core_hold !== e_hold || load_done !== e_done ||
        load_error !== e_err || words_loaded !== e_words) begin
      failures++;
      $display("FAIL %s got rdy=%b hold=%b done=%b err=%b words=%0d exp rdy=%b hold=%b done=%b err=%b words=%0d",
               tag, in_ready, core_hold, load_done, load_error, words_loaded,
               e_rdy, e_hold, e_done, e_err, e_words);
    end
  endtask

  task automatic check_wr_idle(input string tag);
    checks++;
    if (imem_wr_en !== 1'b0 || imem_wr_addr !== 16'h0000 || imem_wr_data !== 16'h0000) begin
      failures++;
      $display("FAIL %s got en=%b addr=%h data=%h exp en=0 addr=0000 data=0000",
               tag, imem_wr_en, imem_wr_addr, imem_wr_data);
    end
  endtask

  task automatic test_reset();
    #12;
    check_status("reset_status", 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    check_wr_idle("reset_wr");
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_good_frame();
    clear_log();
    frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    send_frame(0);
    check_status("good_status", 1'b0, 1'b0, 1'b1, 1'b0, 16'd2);
    check_writes("good", '{16'h0000, 16'h0002}, '{16'h1234, 16'hABCD});
  endtask

  task automatic test_load_req();
    pulse_req();
    check_status("req_clear", 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic test_bad_chk();
    clear_log();
    frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
    send_frame(0);
    check_status("badchk_status", 1'b0, 1'b1, 1'b0, 1'b1, 16'd2);
    check_writes("badchk", '{16'h0000, 16'h0002}, '{16'h1234, 16'hABCD});
    pulse_req();
    check_status("badchk_req", 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
  endtask

  task automatic test_bad_len();
    clear_log();
    send_byte(8'h00, 0);
    check_status("len0_mid", 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    send_byte(8'h00, 0);
    check_status("len0_err", 1'b0, 1'b1, 1'b0, 1'b1, 16'd0);
    pulse_req();
    send_byte(8'h80, 0);
    send_byte(8'h01, 0);
    check_status("len8001_err", 1'b0, 1'b1, 1'b0, 1'b1, 16'd0);
    repeat (2) begin @(posedge clk); #1; end
    check_writes("badlen", '{}, '{});
    pulse_req();
  endtask

  task automatic test_gaps();
    clear_log();
    frame = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
    send_frame(1);
    check_status("gaps_status", 1'b0, 1'b0, 1'b1, 1'b0, 16'd2);
    check_writes("gaps", '{16'h0000, 16'h0002}, '{16'h1234, 16'hABCD});
    checks++;
    if (double_wr !== 0) begin
      failures++;
      $display("FAIL gaps_single_pulse got=%0d exp=0", double_wr);
    end
    pulse_req();
  endtask

  task automatic test_rst_mid();
    frame = '{8'h00, 8'h04, 8'h11, 8'h22, 8'h33};
    send_frame(0);
    check_status("mid_before_rst", 1'b1, 1'b1, 1'b0, 1'b0, 16'd1);
    #2 rst = 1'b1;
    #1;
    check_status("mid_rst_async", 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    check_wr_idle("mid_rst_wr");
    @(posedge clk); #1;
    rst = 1'b0;
    clear_log();
    frame = '{8'h00, 8'h01, 8'h00, 8'hFF, 8'hFF};
    send_frame(0);
    check_status("mid_after_status", 1'b0, 1'b0, 1'b1, 1'b0, 16'd1);
    check_writes("mid_after", '{16'h0000}, '{16'h00FF});
  endtask

  task automatic test_back_to_back();
    pulse_req();
    check_status("b2b_req", 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    clear_log();
    frame = '{8'h00, 8'h03, 8'h01, 8'h02};
    send_frame(0);
    pulse_req();
    frame = '{8'h03, 8'h04, 8'h05, 8'h06, 8'h07};
    send_frame(0);
    check_status("b2b_status", 1'b0, 1'b0, 1'b1, 1'b0, 16'd3);
    check_writes("b2b", '{16'h0000, 16'h0002, 16'h0004}, '{16'h0102, 16'h0304, 16'h0506});
  endtask

  task automatic test_req_with_byte();
    clear_log();
    in_valid = 1'b1; in_data = 8'h00; load_req = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; load_req = 1'b0;
    check_status("reqbyte_restart", 1'b1, 1'b1, 1'b0, 1'b0, 16'd0);
    frame = '{8'h00, 8'h01, 8'hAB, 8'hCD, 8'h66};
    send_frame(0);
    check_status("reqbyte_status", 1'b0, 1'b0, 1'b1, 1'b0, 16'd1);
    check_writes("reqbyte", '{16'h0000}, '{16'hABCD});
    checks++;
    if (double_wr !== 0) begin
      failures++;
      $display("FAIL final_single_pulse got=%0d exp=0", double_wr);
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_load_req();
    test_bad_chk();
    test_bad_len();
    test_gaps();
    test_rst_mid();
    test_back_to_back();
    test_req_with_byte();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
